serial_sub30: RTL and testbench
===============================

// Module: serial_sub30
// PURPOSE
//  Bit-serial two's-complement subtractor: Diff = Reg1 - Reg2, one bit per clock, LSB first.
//  Reuses one full-adder cell over WIDTH cycles (A + ~B + 1), trading latency for area.
//  Sits beside the ripple adder in the datapath; valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  30  operand/result width in bits; must be >= 2
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands present on Reg1/Reg2
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  Reg1       in   WIDTH  minuend
//  Reg2       in   WIDTH  subtrahend
//  out_valid  out  1      Diff/Borrow/Overflow valid (high only in DONE)
//  out_ready  in   1      consumer takes result
//  Diff       out  WIDTH  Reg1 - Reg2 modulo 2^WIDTH
//  Borrow     out  1      1 when Reg1 < Reg2 unsigned (= ~final carry-out)
//  Overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (reset==0, any time, async): state=IDLE, in_ready=1; out_valid, Diff, Borrow,
//   Overflow, count and the operand and carry registers all = 0.
//   A reset during RUN abandons the operation. No partial result is ever presented.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. On in_valid&&in_ready, capture Reg1->a_sh, ~Reg2->b_sh,
//    carry=1, count=0, then go to RUN. While in_valid=0, stay in IDLE.
//   RUN: each cycle feed the cell a_sh[0], b_sh[0], carry. Shift a_sh and b_sh right.
//    Shift the cell's sum into d_sh[WIDTH-1] (d_sh shifts right). carry <= cell cout.
//    count++. When count==WIDTH-2, also latch cell cout into c_msb_in.
//    When count==WIDTH-1 (last bit), go to DONE.
//   DONE: out_valid=1. Hold Diff=d_sh. Borrow=~carry. Overflow=c_msb_in^carry.
//    All three are stable until out_ready. On out_ready go to IDLE;
//    out_valid drops on the next edge.
//  Latency: the accept edge is E0. Bits are processed on edges E1..E_WIDTH.
//   out_valid is high after E_WIDTH (30 cycles at default).
//   Minimum issue interval is WIDTH+2 cycles (accept, WIDTH bits, 1 DONE cycle).
//  in_valid during RUN/DONE is ignored (in_ready=0); the operands must be re-presented.
//  A change on Reg1/Reg2 after the accept edge does not affect the result.
//  out_ready in IDLE/RUN has no effect.
//  Diff/Borrow/Overflow keep their last values in IDLE/RUN, but they are only
//   meaningful while out_valid=1.
//  Width rules: count is $clog2(WIDTH) bits and does not wrap during an operation.
//   There is no sign extension; all arithmetic is modulo 2^WIDTH.
// STRUCTURE
//  Package serial_sub30_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t
//   - localparam DEF_WIDTH=30
//   - function cnt_w(width) returning $clog2(width)
//  Sub-module sub_bit_cell: combinational 1-bit full adder (a, b, cin -> s, cout).
//   b arrives already inverted. One instance only.
//  Top: FSM, counter, three WIDTH-bit shift registers, carry/c_msb_in flops, output mux.
// TESTING
//  Reg1=5, Reg2=3 -> after 30 cycles out_valid=1, Diff=2, Borrow=0, Overflow=0.
//  Reg1=0, Reg2=1 -> Diff=30'h3FFFFFFF, Borrow=1, Overflow=0.
//  Reg1=30'h20000000, Reg2=1 -> Diff=30'h1FFFFFFF, Borrow=0, Overflow=1.
//  Reg1=30'h1FFFFFFF, Reg2=30'h3FFFFFFF (+max - (-1)) -> Diff=30'h20000000, Borrow=1, Overflow=1.
//  Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//   A new in_valid is ignored. On out_ready=1 -> IDLE next edge.
//  Drop reset at RUN count=12 -> all outputs 0, IDLE. Then 7-7 -> Diff=0, Borrow=0, Overflow=0.
//  Change Reg1/Reg2 on every edge during RUN -> result equals the accepted pair.
//  Random 500 pairs against a reference model of Reg1-Reg2, borrow and signed overflow.

Source files
------------

// File: rtl/serial_sub30_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub30_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEF_WIDTH = 30;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub30_sub_bit_cell.sv
// One-bit full adder; the subtrahend bit arrives already inverted.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub30.sv
// Bit-serial two's-complement subtractor: Diff = Reg1 - Reg2, LSB first,
// computed as Reg1 + ~Reg2 + 1 through a single full-adder cell.
module serial_sub30
    import serial_sub30_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Reg1,
    input  logic [WIDTH-1:0] Reg2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Overflow,
    output sub_state_t       dbg_state
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);

    sub_state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic [CW-1:0]    count;
    logic             carry, c_msb_in;
    logic             cell_s, cell_cout;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, ovf_q;

    sub_bit_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (count == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            count    <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= Reg1;
                        b_sh  <= ~Reg2;
                        carry <= 1'b1;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    d_sh  <= {cell_s, d_sh[WIDTH-1:1]};
                    carry <= cell_cout;
                    // Carry out of bit WIDTH-2 is the carry into the sign bit.
                    if (count == PEN) c_msb_in <= cell_cout;
                    if (count == LAST) begin
                        diff_q   <= {cell_s, d_sh[WIDTH-1:1]};
                        borrow_q <= ~cell_cout;
                        ovf_q    <= c_msb_in ^ cell_cout;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff      = diff_q;
    assign Borrow    = borrow_q;
    assign Overflow  = ovf_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_sub30.sv
// Self-checking bench for serial_sub30: vector table, corner sequences, random pairs.
module tb_serial_sub30;
    import serial_sub30_pkg::*;

    localparam int W = 30;
    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t r1;
        word_t r2;
        word_t diff;
        logic  borrow;
        logic  ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    word_t      Reg1, Reg2, Diff;
    logic       Borrow, Overflow;
    sub_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    serial_sub30 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Reg1      (Reg1),
        .Reg2      (Reg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Borrow    (Borrow),
        .Overflow  (Overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input word_t r1, input word_t r2);
        word_t d;
        logic  b, o;
        d = r1 - r2;
        b = (r1 < r2);
        o = (r1[W-1] ^ r2[W-1]) & (d[W-1] ^ r1[W-1]);
        return {d, b, o};
    endfunction

    // Presents operands at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input word_t r1, input word_t r2, input logic [W+1:0] e, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("issue_ready_timeout", in_ready, 1);
        Reg1     = r1;
        Reg2     = r2;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(output int lat);
        logic [W+1:0] e;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", out_valid, 1);
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("diff", Diff, e[W+1:2]);
            check("borrow", Borrow, e[1]);
            check("overflow", Overflow, e[0]);
            check("in_ready_done", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_idle", in_ready, 1);
    endtask

    initial begin
        vec_t  vecs[8];
        int    lat;
        word_t r1, r2;
        logic [W+1:0] e;

        vecs[0] = '{30'd5,          30'd3,          30'd2,          1'b0, 1'b0};
        vecs[1] = '{30'd0,          30'd1,          30'h3FFFFFFF,   1'b1, 1'b0};
        vecs[2] = '{30'h20000000,   30'd1,          30'h1FFFFFFF,   1'b0, 1'b1};
        vecs[3] = '{30'h1FFFFFFF,   30'h3FFFFFFF,   30'h20000000,   1'b1, 1'b1};
        vecs[4] = '{30'h3FFFFFFF,   30'd0,          30'h3FFFFFFF,   1'b0, 1'b0};
        vecs[5] = '{30'd0,          30'h20000000,   30'h20000000,   1'b1, 1'b1};
        vecs[6] = '{30'd0,          30'd0,          30'd0,          1'b0, 1'b0};
        vecs[7] = '{30'h3FFFFFFF,   30'h3FFFFFFF,   30'd0,          1'b0, 1'b0};

        // Clock/reset
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Reg1      = '0;
        Reg2      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 0);
        check("rst_borrow", Borrow, 0);
        check("rst_overflow", Overflow, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        @(negedge clk);

        // Vector table with latency check
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].r1, vecs[i].r2, {vecs[i].diff, vecs[i].borrow, vecs[i].ovf}, 1'b1);
            collect(lat);
            check("latency", lat, W);
        end

        // Result held under back-pressure; new requests ignored in DONE
        issue(30'd5, 30'd3, {30'd2, 1'b0, 1'b0}, 1'b1);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            Reg1     = word_t'($urandom);
            Reg2     = word_t'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_diff", Diff, 2);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        collect(lat);
        repeat (3) begin
            @(negedge clk);
            check("ignored_req_idle", dbg_state, IDLE);
        end

        // Asynchronous reset mid-operation (count == 12), then 7-7
        issue(30'h12345, 30'h54321, '0, 1'b0);
        repeat (12) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_state", dbg_state, IDLE);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_diff", Diff, 0);
        check("midrst_borrow", Borrow, 0);
        check("midrst_overflow", Overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(30'd7, 30'd7, {30'd0, 1'b0, 1'b0}, 1'b1);
        collect(lat);
        check("post_rst_latency", lat, W);

        // Operands wiggle every cycle after the accept edge
        r1 = 30'h0ABCDEF;
        r2 = 30'h3000001;
        issue(r1, r2, model(r1, r2), 1'b1);
        repeat (W - 1) begin
            Reg1 = word_t'($urandom);
            Reg2 = word_t'($urandom);
            @(negedge clk);
        end
        collect(lat);

        // Random pairs against the reference model
        for (int i = 0; i < 500; i++) begin
            r1 = word_t'($urandom);
            r2 = word_t'($urandom);
            if (i % 10 == 0) r2 = word_t'($urandom_range(0, 3));
            e = model(r1, r2);
            issue(r1, r2, e, 1'b1);
            collect(lat);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
